// File: rtl/alarm_pkg.sv
// Shared constants and FSM encoding for the multi-channel alarm bank.
// Imported by alarm_channel and alarm_bank.
package alarm_pkg;

    localparam int TIME_W   = 6;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: minute/hour/enable registers with wrap and toggle,
// plus a combinational match against the running clock.
// Ports: clock/reset, edit controls qualified by selected, current time in,
// stored minute/hour/en out, match out.
module alarm_channel
    import alarm_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              selected,
    input  logic              minute_set,
    input  logic              hour_set,
    input  logic              enable_toggle,
    input  logic              sec_tick,
    input  logic [TIME_W-1:0] cur_second,
    input  logic [TIME_W-1:0] cur_minute,
    input  logic [TIME_W-1:0] cur_hour,
    output logic [TIME_W-1:0] minute,
    output logic [TIME_W-1:0] hour,
    output logic              en,
    output logic              match
);

    logic editing;

    assign editing = selected && (minute_set || hour_set);

    always_ff @(posedge clock) begin
        if (reset) begin
            minute <= '0;
            hour   <= '0;
            en     <= 1'b0;
        end else if (selected) begin
            if (minute_set) begin
                minute <= (minute == TIME_W'(MIN_MAX)) ? '0 : minute + TIME_W'(1);
            end
            if (hour_set) begin
                hour <= (hour == TIME_W'(HOUR_MAX)) ? '0 : hour + TIME_W'(1);
            end
            if (enable_toggle) begin
                en <= ~en;
            end
        end
    end

    // A channel under edit must not fire on a half-entered time.
    assign match = sec_tick
                && (cur_second == '0)
                && (cur_minute == minute)
                && (cur_hour == hour)
                && en
                && !editing;

endmodule

// File: rtl/alarm_bank.sv
// Bank of NUM_ALARMS hour:minute alarms with a shared ring/snooze FSM.
// Ports: clock/reset, sec_tick + current time, sel/edit controls,
// stop/snooze; outputs selected channel view, enable_mask, ring, ring_id.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS   = 4,
    parameter int SEL_W        = 2,
    parameter int RING_SECONDS = 30,
    parameter int SNOOZE_MIN   = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sec_tick,
    input  logic [TIME_W-1:0]     cur_second,
    input  logic [TIME_W-1:0]     cur_minute,
    input  logic [TIME_W-1:0]     cur_hour,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  minute_set,
    input  logic                  hour_set,
    input  logic                  enable_toggle,
    input  logic                  stop,
    input  logic                  snooze,
    output logic [TIME_W-1:0]     second_data,
    output logic [TIME_W-1:0]     minute_data,
    output logic [TIME_W-1:0]     hour_data,
    output logic                  sel_enable,
    output logic [NUM_ALARMS-1:0] enable_mask,
    output logic                  ring,
    output logic [SEL_W-1:0]      ring_id
);

    localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
    localparam int CNT_MAX = (RING_SECONDS > SNOOZE_TICKS) ? RING_SECONDS : SNOOZE_TICKS;
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECONDS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_TICKS - 1);

    logic [TIME_W-1:0]     min_arr  [NUM_ALARMS];
    logic [TIME_W-1:0]     hour_arr [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] sel_hit;
    logic [NUM_ALARMS-1:0] match;
    logic                  any_match;
    logic [SEL_W-1:0]      win;
    logic                  rid_en;
    logic                  force_idle;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [SEL_W-1:0]  id_next;

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
        assign sel_hit[i] = (sel == SEL_W'(i));

        alarm_channel u_ch (
            .clock         (clock),
            .reset         (reset),
            .selected      (sel_hit[i]),
            .minute_set    (minute_set),
            .hour_set      (hour_set),
            .enable_toggle (enable_toggle),
            .sec_tick      (sec_tick),
            .cur_second    (cur_second),
            .cur_minute    (cur_minute),
            .cur_hour      (cur_hour),
            .minute        (min_arr[i]),
            .hour          (hour_arr[i]),
            .en            (enable_mask[i]),
            .match         (match[i])
        );
    end

    // Read mux: out-of-range sel hits no channel and falls back to channel 0.
    always_comb begin
        minute_data = min_arr[0];
        hour_data   = hour_arr[0];
        sel_enable  = enable_mask[0];
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (sel_hit[i]) begin
                minute_data = min_arr[i];
                hour_data   = hour_arr[i];
                sel_enable  = enable_mask[i];
            end
        end
    end

    assign second_data = '0;

    // Lowest index wins: scan downwards so the last assignment is the lowest.
    always_comb begin
        win = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (match[i]) begin
                win = SEL_W'(i);
            end
        end
    end

    assign any_match = |match;

    always_comb begin
        rid_en = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (ring_id == SEL_W'(i)) begin
                rid_en = enable_mask[i];
            end
        end
    end

    // Leave the ring as soon as the owning channel is disabled, including
    // the cycle in which the disabling toggle is applied.
    assign force_idle = !rid_en
                     || (enable_toggle && (sel == ring_id) && (|sel_hit));

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ring_id <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            ring_id <= id_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        id_next    = ring_id;
        unique case (state)
            IDLE: begin
                if (any_match) begin
                    state_next = RINGING;
                    cnt_next   = '0;
                    id_next    = win;
                end
            end
            RINGING: begin
                if (stop || force_idle) begin
                    state_next = IDLE;
                end else if (snooze) begin
                    state_next = SNOOZED;
                    cnt_next   = '0;
                end else if (sec_tick) begin
                    if (cnt == RING_LAST) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            SNOOZED: begin
                if (stop || force_idle) begin
                    state_next = IDLE;
                end else if (sec_tick) begin
                    if (cnt == SNOOZE_LAST) begin
                        state_next = RINGING;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        ring = (state == RINGING);
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_alarm_bank;

    localparam int NA = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       sec_tick;
    logic [5:0] cur_second;
    logic [5:0] cur_minute;
    logic [5:0] cur_hour;
    logic [1:0] sel;
    logic       minute_set;
    logic       hour_set;
    logic       enable_toggle;
    logic       stop;
    logic       snooze;
    logic [5:0] second_data;
    logic [5:0] minute_data;
    logic [5:0] hour_data;
    logic       sel_enable;
    logic [3:0] enable_mask;
    logic       ring;
    logic [1:0] ring_id;

    alarm_bank #(
        .NUM_ALARMS   (4),
        .SEL_W        (2),
        .RING_SECONDS (30),
        .SNOOZE_MIN   (5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .sec_tick      (sec_tick),
        .cur_second    (cur_second),
        .cur_minute    (cur_minute),
        .cur_hour      (cur_hour),
        .sel           (sel),
        .minute_set    (minute_set),
        .hour_set      (hour_set),
        .enable_toggle (enable_toggle),
        .stop          (stop),
        .snooze        (snooze),
        .second_data   (second_data),
        .minute_data   (minute_data),
        .hour_data     (hour_data),
        .sel_enable    (sel_enable),
        .enable_mask   (enable_mask),
        .ring          (ring),
        .ring_id       (ring_id)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model: alarm table plus mode (0 quiet, 1 ringing, 2 snoozed) and
    // the number of seconds left in the current ring or snooze period.
    int m_min [NA];
    int m_hour[NA];
    bit m_en  [NA];
    int mode;
    int remain;
    int rid;
    int t_h, t_m, t_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  s;
        bit  ok;
        int  w;
        bit  clr;
        if (reset) begin
            for (int i = 0; i < NA; i++) begin
                m_min[i] = 0;
                m_hour[i] = 0;
                m_en[i] = 0;
            end
            mode = 0;
            remain = 0;
            rid = 0;
        end else begin
            s = int'(sel);
            ok = (s < NA);
            w = -1;
            for (int i = NA - 1; i >= 0; i--) begin
                if (sec_tick && cur_second == 0 && m_en[i]
                    && m_min[i] == int'(cur_minute) && m_hour[i] == int'(cur_hour)
                    && !(ok && s == i && (minute_set || hour_set)))
                    w = i;
            end
            clr = (mode != 0) && (!m_en[rid] || (enable_toggle && ok && s == rid));
            case (mode)
                0: if (w >= 0) begin
                    mode = 1; rid = w; remain = 30;
                end
                1: if (stop || clr) mode = 0;
                   else if (snooze) begin mode = 2; remain = 300; end
                   else if (sec_tick) begin
                       remain--;
                       if (remain == 0) mode = 0;
                   end
                default: if (stop || clr) mode = 0;
                   else if (sec_tick) begin
                       remain--;
                       if (remain == 0) begin mode = 1; remain = 30; end
                   end
            endcase
            if (ok) begin
                if (minute_set) m_min[s] = (m_min[s] + 1) % 60;
                if (hour_set) m_hour[s] = (m_hour[s] + 1) % 24;
                if (enable_toggle) m_en[s] = !m_en[s];
            end
        end
    endtask

    task automatic step();
        int idx;
        logic [3:0] mask;
        model_edge();
        @(posedge clock);
        #1;
        idx = (int'(sel) < NA) ? int'(sel) : 0;
        for (int i = 0; i < NA; i++) mask[i] = m_en[i];
        chk("m_minute_data", minute_data, m_min[idx]);
        chk("m_hour_data", hour_data, m_hour[idx]);
        chk("m_sel_enable", sel_enable, m_en[idx]);
        chk("m_enable_mask", enable_mask, mask);
        chk("m_second_data", second_data, 0);
        chk("m_ring", ring, mode == 1);
        chk("m_ring_id", ring_id, rid);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        t_h = h; t_m = m; t_s = s;
        cur_hour = 6'(h); cur_minute = 6'(m); cur_second = 6'(s);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            t_s++;
            if (t_s == 60) begin
                t_s = 0; t_m++;
                if (t_m == 60) begin
                    t_m = 0; t_h = (t_h + 1) % 24;
                end
            end
            set_time(t_h, t_m, t_s);
            sec_tick = 1'b1;
            step();
            sec_tick = 1'b0;
            step();
        end
    endtask

    task automatic toggle(input int ch);
        sel = 2'(ch);
        enable_toggle = 1'b1;
        step();
        enable_toggle = 1'b0;
    endtask

    task automatic set_alarm(input int ch, input int h, input int mn);
        int n;
        sel = 2'(ch);
        n = (mn - m_min[ch] + 60) % 60;
        minute_set = 1'b1;
        repeat (n) step();
        minute_set = 1'b0;
        n = (h - m_hour[ch] + 24) % 24;
        hour_set = 1'b1;
        repeat (n) step();
        hour_set = 1'b0;
        if (!m_en[ch]) toggle(ch);
    endtask

    initial begin
        reset = 1'b1;
        sec_tick = 1'b0;
        sel = '0;
        minute_set = 1'b0;
        hour_set = 1'b0;
        enable_toggle = 1'b0;
        stop = 1'b0;
        snooze = 1'b0;
        set_time(0, 0, 0);

        repeat (5) step();
        reset = 1'b0;
        chk("rst_minute", minute_data, 0);
        chk("rst_hour", hour_data, 0);
        chk("rst_second", second_data, 0);
        chk("rst_ring", ring, 0);
        chk("rst_mask", enable_mask, 0);
        chk("rst_ring_id", ring_id, 0);

        sel = 2'd1;
        minute_set = 1'b1;
        repeat (61) step();
        minute_set = 1'b0;
        chk("min_wrap", minute_data, 1);
        chk("min_wrap_hour", hour_data, 0);

        sel = 2'd2;
        hour_set = 1'b1;
        repeat (25) step();
        hour_set = 1'b0;
        chk("hour_wrap", hour_data, 1);

        sel = 2'd3;
        minute_set = 1'b1;
        hour_set = 1'b1;
        repeat (3) step();
        minute_set = 1'b0;
        hour_set = 1'b0;
        chk("both_min", minute_data, 3);
        chk("both_hour", hour_data, 3);

        set_alarm(1, 7, 30);
        chk("ch1_min", minute_data, 30);
        chk("ch1_hour", hour_data, 7);
        set_time(7, 29, 59);
        tick(1);
        chk("ring_on", ring, 1);
        chk("ring_id1", ring_id, 1);
        tick(29);
        chk("ring_held", ring, 1);
        tick(1);
        chk("ring_auto_off", ring, 0);

        set_alarm(0, 8, 0);
        set_alarm(3, 8, 0);
        set_time(7, 59, 59);
        tick(1);
        chk("prio_ring", ring, 1);
        chk("prio_id0", ring_id, 0);
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        chk("snooze_off", ring, 0);
        tick(299);
        chk("snooze_held", ring, 0);
        tick(1);
        chk("snooze_resume", ring, 1);
        chk("snooze_id", ring_id, 0);
        stop = 1'b1;
        snooze = 1'b1;
        step();
        stop = 1'b0;
        snooze = 1'b0;
        chk("stop_wins", ring, 0);
        set_time(7, 59, 59);
        tick(1);
        chk("idle_rearm", ring, 1);

        toggle(0);
        chk("dis_ring_off", ring, 0);
        chk("dis_mask", enable_mask, 4'b1010);

        toggle(0);
        set_time(7, 59, 59);
        tick(1);
        chk("ring_again", ring, 1);
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_ring", ring, 0);
        chk("mid_rst_mask", enable_mask, 0);
        chk("mid_rst_id", ring_id, 0);
        for (int c = 0; c < NA; c++) begin
            sel = 2'(c);
            step();
            chk("mid_rst_min", minute_data, 0);
            chk("mid_rst_hour", hour_data, 0);
        end
        set_time(0, 0, 59);
        tick(1);
        chk("mid_rst_quiet", ring, 0);

        for (int k = 0; k < 4000; k++) begin
            reset = ($urandom_range(499, 0) == 0);
            sel = 2'($urandom_range(3, 0));
            minute_set = ($urandom_range(9, 0) == 0);
            hour_set = ($urandom_range(19, 0) == 0);
            enable_toggle = ($urandom_range(14, 0) == 0);
            stop = ($urandom_range(39, 0) == 0);
            snooze = ($urandom_range(29, 0) == 0);
            sec_tick = $urandom_range(1, 0) == 1;
            cur_hour = 6'($urandom_range(1, 0));
            cur_minute = 6'($urandom_range(3, 0));
            cur_second = ($urandom_range(2, 0) == 0) ? 6'd0 : 6'($urandom_range(59, 1));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
